// File: rtl/crp16_step_clock.sv
// Clock stepper for the CRP16 datapath: debounced single-step key or free-run divider,
// each accepted request producing one registered HIGH_CYCLES-high / HIGH_CYCLES-low pulse.
module crp16_step_clock #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    parameter int HIGH_CYCLES     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_n,
    input  logic        run,
    input  logic        halt,
    output logic        cpu_clock,
    output logic        busy,
    output logic        key_level,
    output logic [15:0] step_count
);

    localparam int DbWidth  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DivWidth = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int PhWidth  = (HIGH_CYCLES > 1) ? $clog2(HIGH_CYCLES) : 1;

    localparam logic [DbWidth-1:0]  DbLast  = DbWidth'(DEBOUNCE_CYCLES - 1);
    localparam logic [DivWidth-1:0] DivLast = DivWidth'(RUN_DIV - 1);
    localparam logic [PhWidth-1:0]  PhLast  = PhWidth'(HIGH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } stateT;

    logic                sync1_q;
    logic                sync2_q;
    logic                pressed;
    logic [DbWidth-1:0]  dbCount_q;
    logic [DbWidth-1:0]  dbCount_d;
    logic                keyLevel_q;
    logic                keyLevel_d;
    logic                keyLevelDly_q;
    logic                pressEvent;
    logic                runDly_q;
    logic [DivWidth-1:0] divCount_q;
    logic [DivWidth-1:0] divCount_d;
    logic                tick_q;
    logic                tick_d;
    logic                req;
    stateT               state_q;
    stateT               state_d;
    logic [PhWidth-1:0]  phase_q;
    logic [PhWidth-1:0]  phase_d;
    logic [15:0]         stepCount_q;
    logic [15:0]         stepCount_d;
    logic                cpuClock_q;
    logic                busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        dbCount_d  = '0;
        keyLevel_d = keyLevel_q;
        if (pressed != keyLevel_q) begin
            if (dbCount_q == DbLast) begin
                keyLevel_d = pressed;
            end else begin
                dbCount_d = dbCount_q + 1'b1;
            end
        end
    end

    // runDly_q holds the divider at zero for the first run cycle, aligning the first tick.
    always_comb begin
        divCount_d = '0;
        tick_d     = 1'b0;
        if (run && runDly_q) begin
            tick_d     = (divCount_q == DivLast);
            divCount_d = tick_d ? '0 : divCount_q + 1'b1;
        end
    end

    assign pressEvent = keyLevel_q & ~keyLevelDly_q;
    assign req        = run ? tick_q : pressEvent;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        stepCount_d = stepCount_q;
        case (state_q)
            IDLE: begin
                if (req && !halt) begin
                    state_d     = HIGH;
                    phase_d     = '0;
                    stepCount_d = stepCount_q + 16'd1;
                end
            end
            HIGH: begin
                if (phase_q == PhLast) begin
                    state_d = LOW;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            LOW: begin
                if (phase_q == PhLast) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state into flops so cpu_clock never glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            dbCount_q     <= '0;
            keyLevel_q    <= 1'b0;
            keyLevelDly_q <= 1'b0;
            runDly_q      <= 1'b0;
            divCount_q    <= '0;
            tick_q        <= 1'b0;
            state_q       <= IDLE;
            phase_q       <= '0;
            stepCount_q   <= 16'd0;
            cpuClock_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            dbCount_q     <= dbCount_d;
            keyLevel_q    <= keyLevel_d;
            keyLevelDly_q <= keyLevel_q;
            runDly_q      <= run;
            divCount_q    <= divCount_d;
            tick_q        <= tick_d;
            state_q       <= state_d;
            phase_q       <= phase_d;
            stepCount_q   <= stepCount_d;
            cpuClock_q    <= (state_d == HIGH);
            busy_q        <= (state_d != IDLE);
        end
    end

    assign cpu_clock  = cpuClock_q;
    assign busy       = busy_q;
    assign key_level  = keyLevel_q;
    assign step_count = stepCount_q;

endmodule

// File: tb/tb_crp16_step_clock.sv
// Bench for crp16_step_clock: vector table, hand sequences for pulse/halt/reset/wrap corners,
// and randomized stimulus, all compared every cycle against a time-based reference model.
module tb_crp16_step_clock;

    localparam int Deb    = 8;
    localparam int RunDiv = 16;
    localparam int High   = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_n;
    logic        run;
    logic        halt;
    logic        cpu_clock;
    logic        busy;
    logic        key_level;
    logic [15:0] step_count;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state: pulses are tracked by the edge number on which they started.
    int          edgeNo    = 0;
    int          streak    = 0;
    int          runLen    = 0;
    int          lastStart = 0;
    logic        mS1, mS2, mLevel, levelRose, haveStart;
    logic        expCpu, expBusy;
    logic        preloadEn = 1'b0;
    logic [15:0] mCount;

    typedef struct {
        logic        keyN, runIn, haltIn, rstIn;
        int          cycles;
        logic        expCpuV, expBusyV, expLevelV;
        logic [15:0] expCount;
    } vecT;

    vecT vecs[$];

    always #5 clock = ~clock;

    crp16_step_clock #(
        .DEBOUNCE_CYCLES(Deb),
        .RUN_DIV        (RunDiv),
        .HIGH_CYCLES    (High)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .key_n     (key_n),
        .run       (run),
        .halt      (halt),
        .cpu_clock (cpu_clock),
        .busy      (busy),
        .key_level (key_level),
        .step_count(step_count)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelEdge();
        logic pressedNow;
        logic req;
        logic idle;
        edgeNo++;
        if (reset) begin
            mS1 = 1'b1; mS2 = 1'b1; streak = 0; mLevel = 1'b0; levelRose = 1'b0;
            runLen = 0; haveStart = 1'b0; mCount = 16'd0;
        end else begin
            pressedNow = ~mS2;
            runLen = run ? runLen + 1 : 0;
            if (run) req = (runLen >= RunDiv + 2) && (((runLen - 2) % RunDiv) == 0);
            else     req = levelRose;
            idle = !haveStart || (edgeNo - lastStart > 2 * High);
            if (req && !halt && idle) begin
                haveStart = 1'b1;
                lastStart = edgeNo;
                mCount++;
            end
            levelRose = 1'b0;
            if (pressedNow == mLevel) begin
                streak = 0;
            end else begin
                streak++;
                if (streak == Deb) begin
                    mLevel    = pressedNow;
                    levelRose = pressedNow;
                    streak    = 0;
                end
            end
            mS2 = mS1;
            mS1 = key_n;
            if (preloadEn) mCount = 16'hFFFE;
        end
        expCpu  = haveStart && (edgeNo - lastStart < High);
        expBusy = haveStart && (edgeNo - lastStart < 2 * High);
    endtask

    task automatic stepCycle();
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        checkOutput("model cpu_clock", cpu_clock, expCpu);
        checkOutput("model busy", busy, expBusy);
        checkOutput("model key_level", key_level, mLevel);
        checkOutput("model step_count", step_count, mCount);
    endtask

    task automatic applyStimulus(input vecT v, input int idx);
        key_n = v.keyN;
        run   = v.runIn;
        halt  = v.haltIn;
        reset = v.rstIn;
        repeat (v.cycles) stepCycle();
        checkOutput($sformatf("vec%0d cpu_clock", idx), cpu_clock, v.expCpuV);
        checkOutput($sformatf("vec%0d busy", idx), busy, v.expBusyV);
        checkOutput($sformatf("vec%0d key_level", idx), key_level, v.expLevelV);
        checkOutput($sformatf("vec%0d step_count", idx), step_count, v.expCount);
    endtask

    task automatic waitRise(input string name);
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = cpu_clock;
        for (int i = 0; i < 40 && !found; i++) begin
            stepCycle();
            if (cpu_clock && !prev) found = 1'b1;
            prev = cpu_clock;
        end
        checkOutput(name, {15'd0, found}, 16'd1);
    endtask

    function automatic void addVec(input logic k, input logic r, input logic h, input logic rs, input int n,
                                   input logic c, input logic b, input logic l, input logic [15:0] cnt);
        vecT v;
        v.keyN = k; v.runIn = r; v.haltIn = h; v.rstIn = rs; v.cycles = n;
        v.expCpuV = c; v.expBusyV = b; v.expLevelV = l; v.expCount = cnt;
        vecs.push_back(v);
    endfunction

    initial begin
        int          rises[$];
        logic        prevCpu;
        int          highCount;
        int          highLen;
        int          lowLen;
        logic [15:0] wrapExp [3];
        wrapExp = '{16'hFFFF, 16'h0000, 16'h0001};

        // Clean press, release, re-press, then a bouncing key after a fresh reset.
        addVec(0, 0, 0, 0,  9, 0, 0, 0, 16'd0);
        addVec(0, 0, 0, 0,  1, 0, 0, 1, 16'd0);
        addVec(0, 0, 0, 0,  1, 1, 1, 1, 16'd1);
        addVec(0, 0, 0, 0,  1, 1, 1, 1, 16'd1);
        addVec(0, 0, 0, 0,  1, 0, 1, 1, 16'd1);
        addVec(0, 0, 0, 0,  1, 0, 1, 1, 16'd1);
        addVec(0, 0, 0, 0,  1, 0, 0, 1, 16'd1);
        addVec(0, 0, 0, 0, 25, 0, 0, 1, 16'd1);
        addVec(1, 0, 0, 0,  9, 0, 0, 1, 16'd1);
        addVec(1, 0, 0, 0,  1, 0, 0, 0, 16'd1);
        addVec(1, 0, 0, 0,  5, 0, 0, 0, 16'd1);
        addVec(0, 0, 0, 0, 11, 1, 1, 1, 16'd2);
        addVec(0, 0, 0, 0, 10, 0, 0, 1, 16'd2);
        addVec(1, 0, 0, 0, 12, 0, 0, 0, 16'd2);
        addVec(1, 0, 0, 1,  1, 0, 0, 0, 16'd0);
        for (int i = 0; i < 10; i++) addVec(logic'(i % 2), 0, 0, 0, 3, 0, 0, 0, 16'd0);
        addVec(1, 0, 0, 0, 12, 0, 0, 0, 16'd0);

        reset = 1'b1; key_n = 1'b1; run = 1'b0; halt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            checkOutput("reset cpu_clock", cpu_clock, 16'd0);
            checkOutput("reset busy", busy, 16'd0);
            checkOutput("reset key_level", key_level, 16'd0);
            checkOutput("reset step_count", step_count, 16'd0);
        end

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Free-run: rising edges 16 apart, key presses ignored.
        run = 1'b1;
        prevCpu = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            if (c == 10) key_n = 1'b0;
            if (c == 30) key_n = 1'b1;
            stepCycle();
            if (cpu_clock && !prevCpu) rises.push_back(c);
            prevCpu = cpu_clock;
        end
        checkOutput("freerun pulse count", 16'(rises.size()), 16'd4);
        if (rises.size() > 0) checkOutput("freerun first rise", 16'(rises[0]), 16'd18);
        for (int i = 1; i < rises.size(); i++)
            checkOutput("freerun spacing", 16'(rises[i] - rises[i-1]), 16'(RunDiv));
        checkOutput("freerun step_count", step_count, 16'd4);

        // Halt blocks new pulses but never truncates one in progress.
        run = 1'b0;
        repeat (5) stepCycle();
        run = 1'b1; halt = 1'b1;
        highCount = 0;
        for (int i = 0; i < 64; i++) begin
            stepCycle();
            if (cpu_clock) highCount++;
        end
        checkOutput("halt no pulses", 16'(highCount), 16'd0);
        checkOutput("halt step_count", step_count, 16'd4);
        halt = 1'b0;
        waitRise("halt-release rise seen");
        halt = 1'b1;
        highLen = 1; lowLen = 0;
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            if (cpu_clock) highLen++;
            else if (busy) lowLen++;
        end
        checkOutput("halt mid-pulse high len", 16'(highLen), 16'(High));
        checkOutput("halt mid-pulse low len", 16'(lowLen), 16'(High));
        checkOutput("halt mid-pulse step_count", step_count, 16'd5);

        // Reset during HIGH kills the pulse and it does not resume.
        halt = 1'b0;
        waitRise("pre-reset rise seen");
        reset = 1'b1; run = 1'b0;
        stepCycle();
        checkOutput("midreset cpu_clock", cpu_clock, 16'd0);
        checkOutput("midreset busy", busy, 16'd0);
        checkOutput("midreset step_count", step_count, 16'd0);
        reset = 1'b0;
        highCount = 0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (cpu_clock || busy) highCount++;
        end
        checkOutput("post-reset no pulse", 16'(highCount), 16'd0);

        // Wrap: preload the counter near its wrap point to keep the run short.
        run = 1'b1;
        waitRise("wrap first rise seen");
        force dut.stepCount_q = 16'hFFFE;
        preloadEn = 1'b1;
        stepCycle();
        release dut.stepCount_q;
        preloadEn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            waitRise("wrap rise seen");
            checkOutput("wrap step_count", step_count, wrapExp[k]);
        end

        // Randomized segments against the reference model.
        run = 1'b0; halt = 1'b0;
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            len   = int'($urandom_range(1, 24));
            key_n = logic'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) run = ~run;
            halt  = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 39) == 0);
            stepCycle();
            reset = 1'b0;
            repeat (len) stepCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/crp16_step_clock.md
# crp16_step_clock

Board-level clock stepper that sits directly upstream of the CRP16 datapath and produces the processor's `clock` input. It replaces wiring a raw pushbutton to the datapath clock. The block synchronises and debounces the step key, and in free-run mode divides the board clock to a slow step rate. Each accepted request becomes one clean, registered, fixed-width processor clock pulse, and the block counts the steps issued for display.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a key level change is accepted (10 ms at 50 MHz).
- `RUN_DIV`, default 25000000: free-run step period in `clock` cycles; must be ≥ 2*`HIGH_CYCLES`+1.
- `HIGH_CYCLES`, default 4: cycles `cpu_clock` is held high, and also the minimum cycles it is then held low; ≥ 1.
- `clock`  in  1  board clock; every register in the block uses its rising edge. One clock only.
- `reset`  in  1  synchronous, active-high reset.
- `key_n`  in  1  raw active-low step pushbutton; asynchronous and bouncy.
- `run`  in  1  1 = free-run at `RUN_DIV` rate; 0 = single-step on key press.
- `halt`  in  1  1 = suppress new pulses. A pulse already in progress completes.
- `cpu_clock`  out  1  processor clock, registered; idles low; each rising edge is one processor step.
- `busy`  out  1  1 while a pulse (high or low phase) is in progress.
- `key_level`  out  1  debounced key state, 1 = pressed (for LEDR).
- `step_count`  out  16  number of pulses issued; wraps from 0xFFFF to 0x0000.

## Operation
- **Synchroniser:** two flops on `key_n`, both reset to 1 (released). The sampled value is `pressed = ~s2`.
- **Debouncer:**
  - The counter is cleared whenever `pressed == key_level`, and increments otherwise.
  - When the counter equals `DEBOUNCE_CYCLES`-1 and the sample still differs, `key_level <= pressed` and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- **Press event:** `key_level & ~key_level_d`, where `key_level_d` is a registered copy of `key_level`. It is one cycle wide. Release generates nothing.
- **Divider:**
  - When `run`=1, the divider counts 0..`RUN_DIV`-1 and wraps, asserting `tick` in the terminal cycle.
  - When `run`=0, the counter is held at 0 and there is no tick.
- **Request selection:** `req = run ? tick : press_event`. Press events while `run`=1 are discarded.
- **FSM** has states IDLE, HIGH and LOW, with a phase counter counting 0..`HIGH_CYCLES`-1.
  - IDLE: `cpu_clock`=0, `busy`=0. If `req & ~halt`, go to HIGH, clear the phase counter, and increment `step_count` on the same edge. Otherwise the request is dropped.
  - HIGH: `cpu_clock`=1, `busy`=1. After `HIGH_CYCLES` cycles, go to LOW.
  - LOW: `cpu_clock`=0, `busy`=1. After `HIGH_CYCLES` cycles, go to IDLE.
  - Requests arriving in HIGH or LOW are dropped, not queued.
- **Output decode:** `cpu_clock` and `busy` come from a registered state decode, so `cpu_clock` is glitch-free.
- **Mode change mid-pulse:** the pulse completes. Toggling `run` clears the divider.
- **Halt:**
  - `halt` is evaluated only in IDLE.
  - Deasserting `halt` does not replay dropped requests.
- **Reset** (at any time, including mid-pulse):
  - On the next edge: state IDLE, `cpu_clock`=0, `busy`=0, `key_level`=0, `step_count`=0, all counters 0, synchroniser = released.
  - If the key is held through reset, it is debounced afresh and yields one press event.

## Timing
- Key to step: `key_n` is low and stable from before edge E. Then:
  - `s2` goes low after edge E+1.
  - `key_level` goes 1 after edge E+1+`DEBOUNCE_CYCLES`.
  - `cpu_clock` rises after edge E+2+`DEBOUNCE_CYCLES`.
  - `step_count` updates on that same edge.
- Pulse shape: exactly `HIGH_CYCLES` cycles high, then `HIGH_CYCLES` cycles low, then at least 1 IDLE cycle. The minimum spacing between rising edges is 2*`HIGH_CYCLES`+1 cycles.
- Free-run: the first rising edge of `cpu_clock` occurs `RUN_DIV`+1 edges after `run` is first sampled 1. Subsequent rising edges are exactly `RUN_DIV` cycles apart, and no ticks are lost while `halt`=0.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles never changes `key_level`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=8, `RUN_DIV`=16, `HIGH_CYCLES`=2.
1. Reset with `key_n`=1 and `run`=0 → `cpu_clock`=0, `busy`=0, `key_level`=0, `step_count`=0x0000 on every cycle, for 20 cycles.
2. Clean press:
   - Stimulus: `key_n` driven low before edge E and held for 40 cycles, then released.
   - Required: `cpu_clock` is high after edges E+10 and E+11, low from E+12; `busy` is low again after E+14; `step_count`=1; only one pulse while held.
   - Re-press → `step_count`=2.
3. Bounce: `key_n` toggles every 3 cycles for 30 cycles, then stays high → `key_level` stays 0, no `cpu_clock` pulse, `step_count`=0.
4. Free-run: `run`=1 for 66 cycles → 4 pulses with rising edges exactly 16 cycles apart, `step_count`=4. Key presses during this window add no pulses.
5. Halt: `run`=1 and `halt`=1 for 64 cycles → `cpu_clock` stays 0 and `step_count` is unchanged. Asserting `halt` during HIGH → that pulse still completes its full 2+2 cycles.
6. Reset and wrap:
   - Assert `reset` for 1 cycle during HIGH → `cpu_clock`=0, `busy`=0, `step_count`=0 after that edge, and no pulse resumes.
   - Free-run 65537 pulses → `step_count` reads 0xFFFF, then 0x0000, then 0x0001.
